// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO for any depth (not only powers of two). It provides an
// occupancy count, programmable almost-full and almost-empty flags, and
// one-cycle overflow and underflow pulses.
// Two read modes are available: a registered standard read, or
// first-word-fall-through (FWFT).
module sync_fifo_flags #(
  parameter int unsigned DATA_LEN   = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_LEN   = 3,
  parameter int unsigned AFULL_THR  = DEPTH - 1,
  parameter int unsigned AEMPTY_THR = 1,
  parameter int unsigned FWFT       = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [DATA_LEN-1:0] indata,
  input  logic                pop,
  output logic [DATA_LEN-1:0] outdata,
  output logic                empty,
  output logic                full,
  output logic                almost_empty,
  output logic                almost_full,
  output logic [ADDR_LEN:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int unsigned CntW = ADDR_LEN + 1;

  // Reject parameter combinations that cannot work at elaboration time.
  if ((2 ** ADDR_LEN) < DEPTH) begin : g_addr_chk
    $error("ADDR_LEN too small for DEPTH");
  end
  if (DEPTH < 2) begin : g_depth_chk
    $error("DEPTH must be at least 2");
  end
  if (AFULL_THR < 1 || AFULL_THR > DEPTH || AEMPTY_THR >= DEPTH) begin : g_thr_chk
    $error("almost flag thresholds out of range");
  end

  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [ADDR_LEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_LEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                overflow_q, underflow_q;
  logic                push_acc, pop_acc;

  // Accept decode. A pop while full frees the slot the push needs in the same cycle.
  always_comb begin
    pop_acc  = pop & (count_q != '0);
    push_acc = push & ((count_q != CntW'(DEPTH)) | pop_acc);
  end

  // Next-state computation for the pointers (wrapping at DEPTH-1) and the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) begin
      wr_ptr_d = (wr_ptr_q == ADDR_LEN'(DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_LEN'(1);
    end
    if (pop_acc) begin
      rd_ptr_d = (rd_ptr_q == ADDR_LEN'(DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_LEN'(1);
    end
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; rst has priority over push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= push & ~push_acc;
      underflow_q <= pop & ~pop_acc;
    end
  end

  // Storage write. Storage is not reset; when full, a read of the same slot sees the old word.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      mem[wr_ptr_q] <= indata;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Show the head word combinationally. It is only meaningful while not empty.
    always_comb begin
      outdata = mem[rd_ptr_q];
    end
  end else begin : g_std
    logic [DATA_LEN-1:0] rdata_q;
    // Registered read. The data is loaded on an accepted pop and held otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (pop_acc) begin
        rdata_q <= mem[rd_ptr_q];
      end
    end
    always_comb begin
      outdata = rdata_q;
    end
  end

  // All flags are decoded from the registered count.
  always_comb begin
    count        = count_q;
    empty        = (count_q == '0);
    full         = (count_q == CntW'(DEPTH));
    almost_empty = (count_q <= CntW'(AEMPTY_THR));
    almost_full  = (count_q >= CntW'(AFULL_THR));
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags. A DEPTH=5 instance in standard read mode
// is driven from a vector table plus a wrap-around sequence. A second instance
// in FWFT mode covers fall-through behaviour and mid-operation reset.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst, push, pop;
  logic [7:0] indata, outdata;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0] count;

  logic       rst2, push2, pop2;
  logic [7:0] indata2, outdata2;
  logic       empty2, full2, almost_empty2, almost_full2, overflow2, underflow2;
  logic [3:0] count2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .DATA_LEN(8), .DEPTH(5), .ADDR_LEN(3), .AFULL_THR(4), .AEMPTY_THR(1), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .push(push), .indata(indata), .pop(pop), .outdata(outdata),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flags #(
    .DATA_LEN(8), .DEPTH(5), .ADDR_LEN(3), .AFULL_THR(4), .AEMPTY_THR(1), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst2), .push(push2), .indata(indata2), .pop(pop2), .outdata(outdata2),
    .empty(empty2), .full(full2), .almost_empty(almost_empty2), .almost_full(almost_full2),
    .count(count2), .overflow(overflow2), .underflow(underflow2)
  );

  // Packed observation: {count, empty, full, almost_empty, almost_full, ovf, unf, outdata}.
  typedef struct {
    logic        push;
    logic [7:0]  data;
    logic        pop;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] obs1();
    return {count, empty, full, almost_empty, almost_full, overflow, underflow, outdata};
  endfunction

  function automatic logic [17:0] mk(int c, bit e, bit f, bit ae, bit af, bit ov, bit un,
                                     logic [7:0] d);
    return {4'(c), e, f, ae, af, ov, un, d};
  endfunction

  task automatic add(bit p, logic [7:0] d, bit q, logic [17:0] e);
    vec_t v;
    v.push = p; v.data = d; v.pop = q; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle on instance 1 and settle just after the active edge.
  task automatic step(bit p, logic [7:0] d, bit q);
    @(negedge clk);
    push = p; indata = d; pop = q;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(bit r, bit p, logic [7:0] d, bit q);
    @(negedge clk);
    rst2 = r; push2 = p; indata2 = d; pop2 = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; indata = '0;
    rst2 = 1'b1; push2 = 1'b0; pop2 = 1'b0; indata2 = '0;

    // Fill: count 1..5, almost_empty clears at 2, almost_full sets at 4.
    add(1, 8'h11, 0, mk(1, 0, 0, 1, 0, 0, 0, 8'h00));
    add(1, 8'h12, 0, mk(2, 0, 0, 0, 0, 0, 0, 8'h00));
    add(1, 8'h13, 0, mk(3, 0, 0, 0, 0, 0, 0, 8'h00));
    add(1, 8'h14, 0, mk(4, 0, 0, 0, 1, 0, 0, 8'h00));
    add(1, 8'h15, 0, mk(5, 0, 1, 0, 1, 0, 0, 8'h00));
    // Push while full: a one-cycle overflow pulse, then drain in order.
    add(1, 8'h99, 0, mk(5, 0, 1, 0, 1, 1, 0, 8'h00));
    add(0, 8'h00, 0, mk(5, 0, 1, 0, 1, 0, 0, 8'h00));
    add(0, 8'h00, 1, mk(4, 0, 0, 0, 1, 0, 0, 8'h11));
    add(0, 8'h00, 1, mk(3, 0, 0, 0, 0, 0, 0, 8'h12));
    add(0, 8'h00, 1, mk(2, 0, 0, 0, 0, 0, 0, 8'h13));
    add(0, 8'h00, 1, mk(1, 0, 0, 1, 0, 0, 0, 8'h14));
    add(0, 8'h00, 1, mk(0, 1, 0, 1, 0, 0, 0, 8'h15));
    // Underflow while empty; outdata holds the last word.
    add(0, 8'h00, 1, mk(0, 1, 0, 1, 0, 0, 1, 8'h15));
    add(0, 8'h00, 0, mk(0, 1, 0, 1, 0, 0, 0, 8'h15));
    // Push and pop together while empty: push accepted, pop rejected.
    add(1, 8'h21, 1, mk(1, 0, 0, 1, 0, 0, 1, 8'h15));
    add(0, 8'h00, 1, mk(0, 1, 0, 1, 0, 0, 0, 8'h21));
    // Full with push and pop together: count holds, no overflow, and 0xAA exits last.
    add(1, 8'hA1, 0, mk(1, 0, 0, 1, 0, 0, 0, 8'h21));
    add(1, 8'hA2, 0, mk(2, 0, 0, 0, 0, 0, 0, 8'h21));
    add(1, 8'hA3, 0, mk(3, 0, 0, 0, 0, 0, 0, 8'h21));
    add(1, 8'hA4, 0, mk(4, 0, 0, 0, 1, 0, 0, 8'h21));
    add(1, 8'hA5, 0, mk(5, 0, 1, 0, 1, 0, 0, 8'h21));
    add(1, 8'hAA, 1, mk(5, 0, 1, 0, 1, 0, 0, 8'hA1));
    add(0, 8'h00, 1, mk(4, 0, 0, 0, 1, 0, 0, 8'hA2));
    add(0, 8'h00, 1, mk(3, 0, 0, 0, 0, 0, 0, 8'hA3));
    add(0, 8'h00, 1, mk(2, 0, 0, 0, 0, 0, 0, 8'hA4));
    add(0, 8'h00, 1, mk(1, 0, 0, 1, 0, 0, 0, 8'hA5));
    add(0, 8'h00, 1, mk(0, 1, 0, 1, 0, 0, 0, 8'hAA));

    repeat (2) @(posedge clk);
    #1;
    check("std_reset", 32'(obs1()), 32'(mk(0, 1, 0, 1, 0, 0, 0, 8'h00)));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].push, vecs[i].data, vecs[i].pop);
      check($sformatf("vec%0d", i), 32'(obs1()), 32'(vecs[i].exp));
    end

    // Wrap-around: hold the fill level at 2 while 12 words pass through.
    step(1, 8'hB0, 0);
    step(1, 8'hB1, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'hB2 + i), 1);
      check($sformatf("wrap%0d", i), {22'd0, count, overflow, underflow, outdata},
            {22'd0, 4'd2, 1'b0, 1'b0, 8'(8'hB0 + i)});
    end
    step(0, 8'h00, 1);
    check("wrap_drain0", {24'd0, outdata}, 32'h0000_00BA);
    step(0, 8'h00, 1);
    check("wrap_drain1", {23'd0, empty, outdata}, {23'd0, 1'b1, 8'hBB});
    step(0, 8'h00, 0);

    // FWFT instance: fall-through visibility, then reset with entries held.
    step2(1, 0, 8'h00, 0);
    check("fwft_reset", {27'd0, count2, empty2}, {27'd0, 4'd0, 1'b1});
    step2(0, 1, 8'h3C, 0);
    check("fwft_fall", {23'd0, empty2, outdata2}, {23'd0, 1'b0, 8'h3C});
    step2(0, 0, 8'h00, 0);
    check("fwft_hold", {24'd0, outdata2}, 32'h0000_003C);
    step2(0, 0, 8'h00, 1);
    check("fwft_pop", {27'd0, count2, empty2}, {27'd0, 4'd0, 1'b1});
    step2(0, 1, 8'h01, 0);
    step2(0, 1, 8'h02, 0);
    step2(0, 1, 8'h03, 0);
    check("fwft_three", {28'd0, count2}, 32'd3);
    step2(1, 0, 8'h00, 0);
    check("fwft_midrst", {27'd0, count2, empty2}, {27'd0, 4'd0, 1'b1});
    step2(0, 1, 8'h5A, 0);
    check("fwft_newword", {23'd0, empty2, outdata2}, {23'd0, 1'b0, 8'h5A});
    step2(0, 0, 8'h00, 1);
    check("fwft_final", {25'd0, count2, empty2, overflow2, underflow2},
          {25'd0, 4'd0, 1'b1, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
